// File: rtl/sys_boot_seq.sv
// sys_boot_seq: table-driven AXI4-Lite initiator that programs the system
// control registers after reset (PLL setup, lock polling, clock enables,
// boot address, core reset release).
//
// Ports
//   clk_i, arst_i       link clock, async active-high reset
//   start_i             start pulse, honoured in IDLE/DONE/ERROR only
//   busy_o/done_o/err_o sequence status; done/err sticky until next start
//   err_code_o          0 none, 1 bresp error, 2 rresp error, 3 poll timeout
//   err_idx_o           index of the failing command
//   cmd_idx_o/cmd_i     command table port, data one cycle after address
//                       cmd_i = {op[97:96], addr[95:64], data[63:32], mask[31:0]}
//   m_aw*/m_w*/m_b*     AXI4-Lite write channels (manager side)
//   m_ar*/m_r*          AXI4-Lite read channels (manager side)
module sys_boot_seq #(
  parameter int NUM_CMDS     = 32,
  parameter int IDX_W        = $clog2(NUM_CMDS),
  parameter int POLL_TIMEOUT = 1024,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [1:0]       err_code_o,
  output logic [IDX_W-1:0] err_idx_o,
  output logic [IDX_W-1:0] cmd_idx_o,
  input  logic [97:0]      cmd_i,
  output logic [31:0]      m_awaddr_o,
  output logic             m_awvalid_o,
  input  logic             m_awready_i,
  output logic [31:0]      m_wdata_o,
  output logic [3:0]       m_wstrb_o,
  output logic             m_wvalid_o,
  input  logic             m_wready_i,
  input  logic [1:0]       m_bresp_i,
  input  logic             m_bvalid_i,
  output logic             m_bready_o,
  output logic [31:0]      m_araddr_o,
  output logic             m_arvalid_o,
  input  logic             m_arready_i,
  input  logic [31:0]      m_rdata_i,
  input  logic [1:0]       m_rresp_i,
  input  logic             m_rvalid_i,
  output logic             m_rready_o
);

  localparam int ATT_W = $clog2(POLL_TIMEOUT + 1);
  localparam logic [1:0] OP_WRITE = 2'd1, OP_POLL = 2'd2, OP_DELAY = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_WR, S_WR_RESP,
    S_RD_ADDR, S_RD_DATA, S_DELAY, S_DONE, S_ERROR
  } state_t;

  state_t           r_state, w_state;
  logic [IDX_W-1:0] r_idx, w_idx, r_err_idx, w_err_idx;
  logic             r_first;
  logic             r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic [1:0]       r_err_code, w_err_code;
  logic             r_awvalid, w_awvalid, r_wvalid, w_wvalid, r_bready, w_bready;
  logic             r_arvalid, w_arvalid, r_rready, w_rready;
  logic [31:0]      r_awaddr, w_awaddr, r_wdata, w_wdata, r_araddr, w_araddr;
  logic [31:0]      r_data, w_data, r_mask, w_mask, r_dcnt, w_dcnt;
  logic [ATT_W-1:0] r_att, w_att;
  logic             w_adv, w_fail;
  logic [1:0]       w_fail_code;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;     r_idx <= '0;      r_err_idx <= '0;
      r_first <= 1'b1;       r_busy <= 1'b0;   r_done <= 1'b0;
      r_err <= 1'b0;         r_err_code <= '0;
      r_awvalid <= 1'b0;     r_wvalid <= 1'b0; r_bready <= 1'b0;
      r_arvalid <= 1'b0;     r_rready <= 1'b0;
      r_awaddr <= '0;        r_wdata <= '0;    r_araddr <= '0;
      r_data <= '0;          r_mask <= '0;     r_dcnt <= '0;
      r_att <= '0;
    end else begin
      r_state <= w_state;    r_idx <= w_idx;   r_err_idx <= w_err_idx;
      r_first <= 1'b0;       r_busy <= w_busy; r_done <= w_done;
      r_err <= w_err;        r_err_code <= w_err_code;
      r_awvalid <= w_awvalid; r_wvalid <= w_wvalid; r_bready <= w_bready;
      r_arvalid <= w_arvalid; r_rready <= w_rready;
      r_awaddr <= w_awaddr;  r_wdata <= w_wdata; r_araddr <= w_araddr;
      r_data <= w_data;      r_mask <= w_mask;   r_dcnt <= w_dcnt;
      r_att <= w_att;
    end
  end

  always_comb begin
    w_state = r_state;     w_idx = r_idx;       w_err_idx = r_err_idx;
    w_busy = r_busy;       w_done = r_done;     w_err = r_err;
    w_err_code = r_err_code;
    w_awvalid = r_awvalid; w_wvalid = r_wvalid; w_bready = r_bready;
    w_arvalid = r_arvalid; w_rready = r_rready;
    w_awaddr = r_awaddr;   w_wdata = r_wdata;   w_araddr = r_araddr;
    w_data = r_data;       w_mask = r_mask;     w_dcnt = r_dcnt;
    w_att = r_att;
    w_adv = 1'b0;          w_fail = 1'b0;       w_fail_code = 2'd0;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        // r_first is only ever set in the IDLE cycle right after reset release
        if (start_i || (AUTO_START && r_first)) begin
          w_idx = '0;  w_done = 1'b0; w_err = 1'b0; w_err_code = 2'd0;
          w_busy = 1'b1; w_state = S_FETCH;
        end
      end
      S_FETCH: w_state = S_DECODE;
      S_DECODE: begin
        w_data = cmd_i[63:32];
        w_mask = cmd_i[31:0];
        case (cmd_i[97:96])
          OP_WRITE: begin
            w_awaddr = cmd_i[95:64]; w_wdata = cmd_i[63:32];
            w_awvalid = 1'b1; w_wvalid = 1'b1; w_state = S_WR;
          end
          OP_POLL: begin
            w_araddr = cmd_i[95:64]; w_arvalid = 1'b1;
            w_att = ATT_W'(1); w_state = S_RD_ADDR;
          end
          OP_DELAY: begin
            w_dcnt = cmd_i[63:32]; w_state = S_DELAY;
          end
          default: begin
            w_busy = 1'b0; w_done = 1'b1; w_state = S_DONE;
          end
        endcase
      end
      S_WR: begin
        // AW and W complete independently; leave once neither is pending
        if (m_awready_i) w_awvalid = 1'b0;
        if (m_wready_i)  w_wvalid  = 1'b0;
        if ((!r_awvalid || m_awready_i) && (!r_wvalid || m_wready_i)) begin
          w_bready = 1'b1; w_state = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (m_bvalid_i) begin
          w_bready = 1'b0;
          if (m_bresp_i == 2'b00) w_adv = 1'b1;
          else begin w_fail = 1'b1; w_fail_code = 2'd1; end
        end
      end
      S_RD_ADDR: begin
        if (m_arready_i) begin
          w_arvalid = 1'b0; w_rready = 1'b1; w_state = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (m_rvalid_i) begin
          w_rready = 1'b0;
          if (m_rresp_i != 2'b00) begin
            w_fail = 1'b1; w_fail_code = 2'd2;
          end else if ((m_rdata_i & r_mask) == r_data) begin
            w_adv = 1'b1;
          end else if (r_att == ATT_W'(POLL_TIMEOUT)) begin
            w_fail = 1'b1; w_fail_code = 2'd3;
          end else begin
            // the RD_DATA cycle itself is the idle gap before the retry
            if (r_att != '1) w_att = r_att + ATT_W'(1);
            w_arvalid = 1'b1; w_state = S_RD_ADDR;
          end
        end
      end
      S_DELAY: begin
        if (r_dcnt == 32'd0) w_adv = 1'b1;
        else                 w_dcnt = r_dcnt - 32'd1;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_adv) begin
      if (r_idx == IDX_W'(NUM_CMDS - 1)) begin
        w_busy = 1'b0; w_done = 1'b1; w_state = S_DONE;
      end else begin
        w_idx = r_idx + IDX_W'(1); w_state = S_FETCH;
      end
    end
    if (w_fail) begin
      w_busy = 1'b0; w_err = 1'b1; w_err_code = w_fail_code;
      w_err_idx = r_idx; w_state = S_ERROR;
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign err_code_o  = r_err_code;
  assign err_idx_o   = r_err_idx;
  assign cmd_idx_o   = r_idx;
  assign m_awaddr_o  = r_awaddr;
  assign m_awvalid_o = r_awvalid;
  assign m_wdata_o   = r_wdata;
  assign m_wstrb_o   = 4'hF;
  assign m_wvalid_o  = r_wvalid;
  assign m_bready_o  = r_bready;
  assign m_araddr_o  = r_araddr;
  assign m_arvalid_o = r_arvalid;
  assign m_rready_o  = r_rready;

endmodule
